icache_set_assoc: RTL and testbench
===================================

// Module: icache_set_assoc
// PURPOSE
//  N-way set-associative instruction cache between Instruction Unit and memory controller.
//  Owns its refill FSM: on miss, requests one block, writes it into a pseudo-LRU victim way, then hits.
//  Adds flush and hit/miss counters. Generalises the direct-mapped fixed-128-bit-block cache.
// PARAMETERS
//  BLOCK_WIDTH  4   log2 bytes per block; >=2; block = 2**(BLOCK_WIDTH-2) words
//  INDEX_WIDTH  6   log2 sets
//  WAYS         2   associativity; 1, 2 or 4
//  CNT_WIDTH    32  width of perf counters
// PORTS
//  clkIn          in   1                     system clock
//  resetIn        in   1                     synchronous, active-low reset
//  flushIn        in   1                     invalidate all lines (1-cycle pulse)
//  instrReqIn     in   1                     fetch request valid
//  instrAddrIn    in   32                    fetch byte address; [1:0] ignored
//  instrOutValid  out  1                     instrOut valid this cycle (hit)
//  instrOut       out  32                    fetched instruction word
//  memReqOut      out  1                     block refill request, level until served
//  memAddrOut     out  32-BLOCK_WIDTH        block address of refill
//  memDataValid   in   1                     refill data valid, 1-cycle pulse
//  memDataIn      in   8*2**BLOCK_WIDTH      refill block, word 0 in LSBs
//  hitCount       out  CNT_WIDTH             saturating hit counter
//  missCount      out  CNT_WIDTH             saturating miss counter
// BEHAVIOUR
//  Address split: tag=[31:BLOCK_WIDTH+INDEX_WIDTH], set=[BLOCK_WIDTH+INDEX_WIDTH-1:BLOCK_WIDTH], word=[BLOCK_WIDTH-1:2].
//  Reset (resetIn==0 at posedge): all valid bits 0, PLRU 0, FSM IDLE, counters 0; memReqOut=0, instrOutValid=0.
//  Tag/valid/PLRU in flops; lookup combinational: instrOutValid = instrReqIn & state==IDLE & any way hit.
//  Zero-cycle hit latency; instrOut = hit way word; when instrOutValid==0, instrOut=0.
//  Multiple ways hitting is illegal; assertion in sim.
//  FSM IDLE: instrReqIn & no hit & !flushIn -> latch block addr, missCount++, go REFILL.
//  Hit in IDLE: hitCount++, PLRU of set updated to mark hit way MRU at posedge.
//  REFILL: memReqOut=1, memAddrOut=latched addr (stable until memDataValid).
//   On memDataValid: write tag/data/valid=1 into victim, mark MRU, -> IDLE. memReqOut drops next cycle.
//   Next cycle same address hits (miss-to-hit = refill latency + 1 cycle).
//  Victim: lowest-index invalid way; else tree-PLRU (WAYS=2: 1 bit/set; 4: 3 bits/set; 1: way 0).
//  instrAddrIn may change during REFILL: refill still completes for latched addr; no output until IDLE.
//  memDataValid in IDLE: ignored, no state change.
//  flushIn: clears all valid bits at posedge. In REFILL: set drop flag; returned block discarded, -> IDLE.
//   flushIn & memDataValid same cycle: flush wins, block discarded. Flush never drops memReqOut early.
//  Reset mid-REFILL: FSM IDLE, memReqOut 0 next cycle; controller must also be reset.
//  Counters saturate at all-ones; no wrap.
// STRUCTURE
//  Shared package: FSM state enum (IDLE, REFILL), address-slice width localparams, PLRU encoding.
//  Sub-module icache_plru: per-set tree-PLRU state, update-on-access and victim-select, parametrised by WAYS.
//  Data array as per-way register arrays; one generate loop over ways for tag compare.
// TESTING
//  1 Reset then fetch 0x0000_1000: miss, memReqOut=1, memAddrOut=0x100; return block -> next cycle hit, missCount=1.
//  2 WAYS=2: fill 0x1000, 0x2000 (same set); touch 0x1000; miss 0x3000 -> evicts 0x2000; 0x1000 still hits.
//  3 Fetch 0x1004, 0x1008, 0x100C after fill: three hits, words 1..3 of block, hitCount=3.
//  4 Flush during REFILL then memDataValid: no line written, re-fetch misses again, memReqOut reasserted.
//  5 resetIn=0 mid-REFILL, stray memDataValid in IDLE: memReqOut=0, no valid bits set, counters 0.
//  6 Force hitCount to all-ones-1, two hits: saturates at all-ones.

Source files
------------

// File: rtl/icache_set_assoc_pkg.sv
// Shared types and constants for the set-associative instruction cache.
// Holds the refill FSM encoding, address geometry and tree-PLRU bit layout.
package icache_set_assoc_pkg;

  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned WORD_WIDTH  = 32;
  localparam int unsigned WORD_OFFSET = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } cacheState_e;

  // Tree-PLRU bit positions: root picks the half, LEFT/RIGHT pick the way in it.
  // Each bit points at the half/way that is the next victim.
  localparam int unsigned PLRU_ROOT  = 0;
  localparam int unsigned PLRU_LEFT  = 1;
  localparam int unsigned PLRU_RIGHT = 2;

  function automatic int unsigned plruBits(input int unsigned ways);
    return (ways == 4) ? 3 : 1;
  endfunction

endpackage

// File: rtl/icache_plru.sv
// Per-set tree pseudo-LRU: marks the touched way MRU and names the victim of a set.
// WAYS=1 has no state and always picks way 0.
module icache_plru
  import icache_set_assoc_pkg::*;
#(
  parameter int unsigned WAYS        = 2,
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned WAY_WIDTH   = 1
) (
  input  logic                   clkIn,
  input  logic                   resetIn,
  input  logic                   touchEn,
  input  logic [INDEX_WIDTH-1:0] touchSet,
  input  logic [WAY_WIDTH-1:0]   touchWay,
  input  logic [INDEX_WIDTH-1:0] victimSet,
  output logic [WAY_WIDTH-1:0]   victimWay
);

  localparam int unsigned SETS   = 1 << INDEX_WIDTH;
  localparam int unsigned PLRU_W = plruBits(WAYS);

  generate
    if (WAYS == 1) begin : gNoPlru
      assign victimWay = '0;
    end else begin : gTree
      logic [PLRU_W-1:0] plruMem [SETS];
      logic [PLRU_W-1:0] curBits;
      logic [PLRU_W-1:0] nextBits;

      assign curBits = plruMem[victimSet];

      always_ff @(posedge clkIn) begin
        if (!resetIn) begin
          for (int s = 0; s < int'(SETS); s++) begin
            plruMem[s] <= '0;
          end
        end else if (touchEn) begin
          plruMem[touchSet] <= nextBits;
        end
      end

      if (WAYS == 4) begin : gFour
        // Point the root and the touched pair's bit away from the touched way.
        always_comb begin
          nextBits            = plruMem[touchSet];
          nextBits[PLRU_ROOT] = ~touchWay[1];
          if (touchWay[1]) begin
            nextBits[PLRU_RIGHT] = ~touchWay[0];
          end else begin
            nextBits[PLRU_LEFT] = ~touchWay[0];
          end
        end
        assign victimWay = curBits[PLRU_ROOT] ? {1'b1, curBits[PLRU_RIGHT]}
                                              : {1'b0, curBits[PLRU_LEFT]};
      end else begin : gTwo
        assign nextBits  = ~touchWay;
        assign victimWay = curBits;
      end
    end
  endgenerate

endmodule

// File: rtl/icache_set_assoc.sv
// N-way set-associative instruction cache with its own single-block refill FSM,
// flush, and saturating hit/miss counters. Lookup is combinational (zero-cycle hit).
module icache_set_assoc
  import icache_set_assoc_pkg::*;
#(
  parameter int unsigned BLOCK_WIDTH = 4,
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                              clkIn,
  input  logic                              resetIn,
  input  logic                              flushIn,
  input  logic                              instrReqIn,
  input  logic [ADDR_WIDTH-1:0]             instrAddrIn,
  output logic                              instrOutValid,
  output logic [WORD_WIDTH-1:0]             instrOut,
  output logic                              memReqOut,
  output logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] memAddrOut,
  input  logic                              memDataValid,
  input  logic [8*(2**BLOCK_WIDTH)-1:0]     memDataIn,
  output logic [CNT_WIDTH-1:0]              hitCount,
  output logic [CNT_WIDTH-1:0]              missCount
);

  localparam int unsigned TAG_WIDTH      = ADDR_WIDTH - BLOCK_WIDTH - INDEX_WIDTH;
  localparam int unsigned BLK_ADDR_WIDTH = ADDR_WIDTH - BLOCK_WIDTH;
  localparam int unsigned SETS           = 1 << INDEX_WIDTH;
  localparam int unsigned BLOCK_BITS     = 8 << BLOCK_WIDTH;
  localparam int unsigned WORD_SEL_WIDTH = (BLOCK_WIDTH > 2) ? BLOCK_WIDTH - 2 : 1;
  localparam int unsigned WAY_WIDTH      = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [TAG_WIDTH-1:0]  tagMem  [WAYS][SETS];
  logic [BLOCK_BITS-1:0] dataMem [WAYS][SETS];
  logic [SETS-1:0]       validMem [WAYS];

  cacheState_e               state, stateNext;
  logic [BLK_ADDR_WIDTH-1:0] missAddr, missAddrNext;
  logic                      dropFlag, dropNext;
  logic                      missEvent, fillEn;

  logic [TAG_WIDTH-1:0]      reqTag;
  logic [INDEX_WIDTH-1:0]    reqSet;
  logic [WORD_SEL_WIDTH-1:0] wordIdx;
  logic [TAG_WIDTH-1:0]      missTag;
  logic [INDEX_WIDTH-1:0]    missSet;
  logic [WAYS-1:0]           wayHit;
  logic                      hitAny;
  logic [WAY_WIDTH-1:0]      hitWay, fillWay, plruVictim;
  logic [BLOCK_BITS-1:0]     hitLine;
  logic [1:0]                unusedAddrBits;

  assign reqTag         = instrAddrIn[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign reqSet         = instrAddrIn[BLOCK_WIDTH +: INDEX_WIDTH];
  assign missTag        = missAddr[BLK_ADDR_WIDTH-1 -: TAG_WIDTH];
  assign missSet        = missAddr[INDEX_WIDTH-1:0];
  assign unusedAddrBits = instrAddrIn[1:0];

  generate
    if (BLOCK_WIDTH > 2) begin : gWordSel
      assign wordIdx = instrAddrIn[BLOCK_WIDTH-1:WORD_OFFSET];
    end else begin : gOneWord
      assign wordIdx = '0;
    end

    for (genvar w = 0; w < int'(WAYS); w++) begin : gWayCmp
      assign wayHit[w] = validMem[w][reqSet] && (tagMem[w][reqSet] == reqTag);
    end
  endgenerate

  always_comb begin
    hitWay = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (wayHit[w]) hitWay = WAY_WIDTH'(w);
    end
  end

  assign hitAny        = |wayHit;
  assign hitLine       = dataMem[hitWay][reqSet];
  assign instrOutValid = instrReqIn && (state == IDLE) && hitAny;
  assign instrOut      = instrOutValid ? hitLine[{wordIdx, 5'b00000} +: WORD_WIDTH] : '0;
  assign memReqOut     = (state == REFILL);
  assign memAddrOut    = missAddr;

  // Refill target: lowest invalid way first, otherwise the PLRU victim.
  always_comb begin
    fillWay = plruVictim;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!validMem[w][missSet]) fillWay = WAY_WIDTH'(w);
    end
  end

  icache_plru #(
    .WAYS       (WAYS),
    .INDEX_WIDTH(INDEX_WIDTH),
    .WAY_WIDTH  (WAY_WIDTH)
  ) uPlru (
    .clkIn    (clkIn),
    .resetIn  (resetIn),
    .touchEn  (instrOutValid || fillEn),
    .touchSet (fillEn ? missSet : reqSet),
    .touchWay (fillEn ? fillWay : hitWay),
    .victimSet(missSet),
    .victimWay(plruVictim)
  );

  // Refill FSM next state; a flush seen during REFILL poisons the returning block.
  always_comb begin
    stateNext    = state;
    missAddrNext = missAddr;
    dropNext     = dropFlag;
    missEvent    = 1'b0;
    fillEn       = 1'b0;
    unique case (state)
      IDLE: begin
        if (instrReqIn && !hitAny && !flushIn) begin
          stateNext    = REFILL;
          missAddrNext = instrAddrIn[ADDR_WIDTH-1:BLOCK_WIDTH];
          dropNext     = 1'b0;
          missEvent    = 1'b1;
        end
      end
      REFILL: begin
        if (flushIn) dropNext = 1'b1;
        if (memDataValid) begin
          stateNext = IDLE;
          dropNext  = 1'b0;
          fillEn    = !dropFlag && !flushIn;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (!resetIn) begin
      state     <= IDLE;
      missAddr  <= '0;
      dropFlag  <= 1'b0;
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      state    <= stateNext;
      missAddr <= missAddrNext;
      dropFlag <= dropNext;
      if (instrOutValid && (hitCount != '1)) hitCount <= hitCount + CNT_WIDTH'(1);
      if (missEvent && (missCount != '1)) missCount <= missCount + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clkIn) begin
    if (!resetIn || flushIn) begin
      for (int w = 0; w < int'(WAYS); w++) begin
        validMem[w] <= '0;
      end
    end else if (fillEn) begin
      validMem[fillWay][missSet] <= 1'b1;
    end
  end

  always_ff @(posedge clkIn) begin
    if (fillEn) begin
      tagMem[fillWay][missSet]  <= missTag;
      dataMem[fillWay][missSet] <= memDataIn;
    end
  end

  // A tag may live in at most one way of a set.
  oneHitWay: assert property (@(posedge clkIn) disable iff (!resetIn) $onehot0(wayHit));

endmodule

// File: tb/tb_icache_set_assoc.sv
// Directed bench for icache_set_assoc: stimulus pushes expected fetch words,
// a negedge monitor pops and compares whenever the cache presents a hit.
module tb_icache_set_assoc;

  localparam int unsigned BW = 4;
  localparam int unsigned IW = 6;
  localparam int unsigned NW = 2;
  localparam int unsigned CW = 4;

  logic          clkIn = 1'b0;
  logic          resetIn, flushIn, instrReqIn;
  logic [31:0]   instrAddrIn;
  logic          instrOutValid;
  logic [31:0]   instrOut;
  logic          memReqOut;
  logic [27:0]   memAddrOut;
  logic          memDataValid;
  logic [127:0]  memDataIn;
  logic [CW-1:0] hitCount, missCount;

  int total = 0;
  int bad   = 0;
  logic [31:0] expQ[$];

  icache_set_assoc #(
    .BLOCK_WIDTH(BW),
    .INDEX_WIDTH(IW),
    .WAYS       (NW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clkIn        (clkIn),
    .resetIn      (resetIn),
    .flushIn      (flushIn),
    .instrReqIn   (instrReqIn),
    .instrAddrIn  (instrAddrIn),
    .instrOutValid(instrOutValid),
    .instrOut     (instrOut),
    .memReqOut    (memReqOut),
    .memAddrOut   (memAddrOut),
    .memDataValid (memDataValid),
    .memDataIn    (memDataIn),
    .hitCount     (hitCount),
    .missCount    (missCount)
  );

  always #5 clkIn = ~clkIn;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Memory image: each word holds its own byte address scrambled by a constant.
  function automatic logic [31:0] wordOf(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [127:0] blockOf(input logic [31:0] a);
    logic [127:0] b;
    logic [31:0]  base;
    base = {a[31:4], 4'b0000};
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = wordOf(base + 32'(i * 4));
    return b;
  endfunction

  // Monitor: every presented hit must match the oldest expected word.
  always @(negedge clkIn) begin
    if (resetIn === 1'b1) begin
      if (instrOutValid) begin
        if (expQ.size() == 0) check("spuriousValid", 32'(instrOutValid), 32'd0);
        else check("instrOut", instrOut, expQ.pop_front());
      end else begin
        check("idleInstrOut", instrOut, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic fetchHit(input logic [31:0] a, input string name);
    instrReqIn  = 1'b1;
    instrAddrIn = a;
    expQ.push_back(wordOf(a));
    tick();
    instrReqIn = 1'b0;
    check({name, "_hitSeen"}, 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  // Issue a missing fetch, then keep requesting a different address during REFILL.
  task automatic startMiss(input logic [31:0] a, input string name);
    instrReqIn  = 1'b1;
    instrAddrIn = a;
    tick();
    check({name, "_memReq"}, 32'(memReqOut), 32'd1);
    check({name, "_memAddr"}, 32'(memAddrOut), a >> 4);
    instrAddrIn = 32'h0000_1000;
    tick();
    tick();
    check({name, "_memAddrHold"}, 32'(memAddrOut), a >> 4);
  endtask

  task automatic returnBlock(input logic [31:0] a, input string name);
    instrReqIn   = 1'b0;
    memDataValid = 1'b1;
    memDataIn    = blockOf(a);
    tick();
    memDataValid = 1'b0;
    check({name, "_memReqDrop"}, 32'(memReqOut), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    resetIn      = 1'b0;
    flushIn      = 1'b0;
    instrReqIn   = 1'b0;
    instrAddrIn  = 32'd0;
    memDataValid = 1'b0;
    memDataIn    = '0;
    tick();
    tick();
    check("rst_memReq", 32'(memReqOut), 32'd0);
    check("rst_hitCount", 32'(hitCount), 32'd0);
    check("rst_missCount", 32'(missCount), 32'd0);
    check("rst_valid", 32'(instrOutValid), 32'd0);
    resetIn = 1'b1;

    // Cold miss, refill, then hits across the block.
    startMiss(32'h0000_1000, "t1");
    returnBlock(32'h0000_1000, "t1");
    fetchHit(32'h0000_1000, "t1");
    check("t1_missCount", 32'(missCount), 32'd1);
    fetchHit(32'h0000_1004, "t3a");
    fetchHit(32'h0000_1008, "t3b");
    fetchHit(32'h0000_100C, "t3c");
    check("t3_hitCount", 32'(hitCount), 32'd4);

    // Same-set replacement: touched 0x1000 survives, 0x2000 evicted by 0x3000.
    startMiss(32'h0000_2000, "t2a");
    returnBlock(32'h0000_2000, "t2a");
    fetchHit(32'h0000_1000, "t2touch");
    startMiss(32'h0000_3000, "t2b");
    returnBlock(32'h0000_3000, "t2b");
    fetchHit(32'h0000_3008, "t2c");
    fetchHit(32'h0000_1004, "t2d");
    startMiss(32'h0000_2000, "t2evicted");
    returnBlock(32'h0000_2000, "t2evicted");
    fetchHit(32'h0000_200C, "t2e");
    fetchHit(32'h0000_1000, "t2f");
    check("t2_hitCount", 32'(hitCount), 32'd9);
    check("t2_missCount", 32'(missCount), 32'd4);

    // Flush during REFILL: block discarded, request held until data returns.
    startMiss(32'h0000_4000, "t4a");
    instrReqIn = 1'b0;
    flushIn    = 1'b1;
    tick();
    flushIn = 1'b0;
    check("t4_memReqHeld", 32'(memReqOut), 32'd1);
    returnBlock(32'h0000_4000, "t4a");
    startMiss(32'h0000_4000, "t4reMiss");
    returnBlock(32'h0000_4000, "t4reMiss");
    fetchHit(32'h0000_4004, "t4b");
    // Flush and data in the same cycle: flush wins.
    startMiss(32'h0000_5000, "t4c");
    instrReqIn   = 1'b0;
    flushIn      = 1'b1;
    memDataValid = 1'b1;
    memDataIn    = blockOf(32'h0000_5000);
    tick();
    flushIn      = 1'b0;
    memDataValid = 1'b0;
    check("t4_sameCycleDrop", 32'(memReqOut), 32'd0);
    startMiss(32'h0000_5000, "t4d");
    returnBlock(32'h0000_5000, "t4d");
    fetchHit(32'h0000_5000, "t4e");
    check("t4_hitCount", 32'(hitCount), 32'd11);
    check("t4_missCount", 32'(missCount), 32'd8);

    // Counter saturation at all-ones (4-bit counters).
    for (int i = 0; i < 3; i++) fetchHit(32'h0000_5004, "t6pre");
    check("t6_hitCountMax1", 32'(hitCount), 32'd14);
    fetchHit(32'h0000_5008, "t6a");
    fetchHit(32'h0000_500C, "t6b");
    check("t6_hitCountSat", 32'(hitCount), 32'd15);
    check("t6_missCount", 32'(missCount), 32'd8);

    // Reset mid-REFILL, then a stray block in IDLE must not create a line.
    startMiss(32'h0000_6000, "t5a");
    instrReqIn = 1'b0;
    resetIn    = 1'b0;
    tick();
    resetIn = 1'b1;
    check("t5_memReqReset", 32'(memReqOut), 32'd0);
    check("t5_hitCountReset", 32'(hitCount), 32'd0);
    check("t5_missCountReset", 32'(missCount), 32'd0);
    memDataValid = 1'b1;
    memDataIn    = blockOf(32'h0000_6000);
    tick();
    memDataValid = 1'b0;
    check("t5_strayMemReq", 32'(memReqOut), 32'd0);
    check("t5_strayMissCount", 32'(missCount), 32'd0);
    startMiss(32'h0000_5000, "t5b");
    returnBlock(32'h0000_5000, "t5b");
    fetchHit(32'h0000_5000, "t5c");
    startMiss(32'h0000_6000, "t5d");
    returnBlock(32'h0000_6000, "t5d");
    fetchHit(32'h0000_600C, "t5e");
    check("t5_hitCount", 32'(hitCount), 32'd2);
    check("t5_missCount", 32'(missCount), 32'd2);

    tick();
    check("final_queueEmpty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
